keypoint_fetch_merge: RTL and testbench
=======================================

// Module: keypoint_fetch_merge
// PURPOSE
// - Downstream of the keypoint detect/filter stage. After that stage signals done, this block reads
//   keypoint SRAM 1 (DoG layer pair 0) and then keypoint SRAM 2 (layer pair 1).
// - Unpacks each 19-bit word {row[8:0], col[9:0]} and emits one merged stream with valid/ready,
//   tagged by layer, for the orientation/descriptor stage.
// - Hides the 1-cycle SRAM read latency with a 2-entry skid FIFO. Sustains 1 keypoint/cycle when ready=1.
// PARAMETERS
// - ADDR_W   11  keypoint SRAM address width (2K entries per layer)
// - ROW_W     9  row field width, din[18:10]
// - COL_W    10  col field width, din[9:0]
// - FIFO_D    2  skid FIFO depth; must be >= RD_LAT+1
// - RD_LAT    1  SRAM read latency in cycles (addr at edge N -> dout valid during cycle N+1)
// PORTS
// - clk              in   1       single clock, rising edge
// - rst              in   1       synchronous, active-high reset
// - start            in   1       1-cycle pulse; accepted only in IDLE
// - kp1_count        in   ADDR_W  entries in SRAM 1 (final write addr of detect stage); sampled at start
// - kp2_count        in   ADDR_W  entries in SRAM 2; sampled at start
// - keypoint_1_addr  out  ADDR_W  SRAM 1 read address (registered)
// - keypoint_1_dout  in   19      SRAM 1 read data
// - keypoint_2_addr  out  ADDR_W  SRAM 2 read address (registered)
// - keypoint_2_dout  in   19      SRAM 2 read data
// - kp_valid         out  1       output word valid
// - kp_ready         in   1       consumer ready; transfer = kp_valid & kp_ready
// - kp_row           out  ROW_W   keypoint row
// - kp_col           out  COL_W   keypoint col
// - kp_layer         out  1       0 = SRAM 1, 1 = SRAM 2
// - kp_last          out  1       high with the final keypoint of the run
// - busy             out  1       high from the cycle after start until done
// - done             out  1       1-cycle pulse after the last transfer (or after an empty run)
// BEHAVIOUR
// - Reset: state=IDLE; addrs=0; kp_valid=0, kp_row/col/layer/last=0; busy=0; done=0; FIFO empty;
//   in-flight counter=0.
// - FSM states: IDLE, RD1, RD2, DRAIN, FIN.
//   - IDLE -start-> RD1 if kp1_count!=0; else RD2 if kp2_count!=0; else FIN.
//   - RD1: issue a read when credit allows (FIFO occupancy + in-flight < FIFO_D); addr increments per issue.
//     After issuing addr kp1_count-1 -> RD2 if kp2_count!=0, else DRAIN.
//   - RD2: same rules on SRAM 2. After issuing addr kp2_count-1 -> DRAIN.
//   - DRAIN: no issues. -> FIN when FIFO empty and in-flight=0.
//   - FIN: done=1 for exactly one cycle -> IDLE; addrs cleared to 0.
// - Issued reads carry a layer tag and a last flag through an RD_LAT-deep valid pipe.
//   last = final addr of the final nonempty layer.
//   Returned data is pushed into the FIFO RD_LAT cycles after issue; the push is never blocked
//   (guaranteed by credit).
// - Output = FIFO head. kp_valid = !empty. Field values stay stable while kp_valid & !kp_ready.
// - Throughput: with kp_ready held 1, transfers are back-to-back.
//   First kp_valid appears 2 cycles after start (1 cycle state entry + RD_LAT).
// - Simultaneous FIFO push and pop: occupancy unchanged, order preserved.
// - Layer switch RD1->RD2 costs no bubble: SRAM 2 addr 0 is issued the cycle after SRAM 1's last issue.
// - start while busy: ignored. Counts above 2^ADDR_W-1 cannot occur (width-bounded).
// - rst mid-run: everything returns to reset values next edge; in-flight data is discarded;
//   no done pulse is produced.
// STRUCTURE
// - Shared package: ROW_W, COL_W, ADDR_W, KP_W=ROW_W+COL_W, state encoding constants,
//   field-slice localparams (ROW_MSB=18, ROW_LSB=10).
// - Sub-module kp_skid_fifo (FIFO_D entries, width KP_W+2 for layer+last; push/pop/full/empty/count).
// - Top module holds the FSM, address counters, credit counter and latency pipe.
// TESTING
// - kp1=3, kp2=2, ready=1: stream (L0 a0,a1,a2),(L1 b0,b1); kp_last on b1; done 1 cycle later;
//   5 consecutive valid cycles.
// - kp1=0, kp2=0: start -> no kp_valid; done pulses within 2 cycles; busy drops.
// - kp1=0, kp2=4: only layer-1 words; addr1 never leaves 0; kp_last on 4th word.
// - kp1=6, ready toggled 1,0,0,1...: no drop, no duplicate; row/col stable while stalled;
//   FIFO never overflows.
// - Packed word 19'h7FC01 -> kp_row=511 (0x1FF), kp_col=1; word 19'h00A7F -> row=2, col=639.
// - rst asserted mid-RD2 with 2 words buffered: next cycle kp_valid=0, addrs=0, busy=0;
//   a new start then replays from addr 0.

Source files
------------

// File: rtl/keypoint_fetch_merge_pkg.sv
// Shared widths, field slices, FSM encoding and the buffered-entry layout for keypoint fetch/merge.
package keypoint_fetch_merge_pkg;
  localparam int ADDR_W  = 11;
  localparam int ROW_W   = 9;
  localparam int COL_W   = 10;
  localparam int KP_W    = ROW_W + COL_W;
  localparam int FIFO_D  = 2;
  localparam int RD_LAT  = 1;
  localparam int ROW_MSB = 18;
  localparam int ROW_LSB = 10;
  localparam int COL_MSB = 9;
  localparam int COL_LSB = 0;
  localparam int ENTRY_W = KP_W + 2;
  localparam int FCNT_W  = $clog2(FIFO_D + 1);
  localparam int INFL_W  = $clog2(RD_LAT + 1);
  localparam int CR_W    = $clog2(FIFO_D + RD_LAT + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD1   = 3'd1,
    S_RD2   = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  typedef struct packed {
    logic             layer;
    logic             last;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } kp_entry_t;

  function automatic kp_entry_t kp_unpack(input logic layer, input logic last,
                                          input logic [KP_W-1:0] word);
    kp_entry_t e;
    e.layer = layer;
    e.last  = last;
    e.row   = word[ROW_MSB:ROW_LSB];
    e.col   = word[COL_MSB:COL_LSB];
    return e;
  endfunction
endpackage

// File: rtl/keypoint_fetch_merge_if.sv
// Merged keypoint stream (valid/ready) toward the orientation/descriptor stage.
interface keypoint_fetch_merge_if;
  import keypoint_fetch_merge_pkg::*;
  logic             valid;
  logic             ready;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             layer;
  logic             last;

  modport master (output valid, row, col, layer, last, input ready);
  modport slave  (input valid, row, col, layer, last, output ready);
endinterface

// File: rtl/keypoint_fetch_merge_skid_fifo.sv
// Small skid FIFO absorbing SRAM read latency; head entry is presented combinationally.
module keypoint_fetch_merge_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 21
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [W-1:0]                 data_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_i) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
endmodule

// File: rtl/keypoint_fetch_merge.sv
// Reads keypoint SRAM 1 then SRAM 2 after detection finishes and emits one layer-tagged stream.
//   state | meaning
//   IDLE  | waiting for start, counts sampled on start
//   RD1   | issuing reads to SRAM 1 (layer 0)
//   RD2   | issuing reads to SRAM 2 (layer 1)
//   DRAIN | no more issues, waiting for FIFO and read pipe to empty
//   FIN   | one-cycle done pulse, addresses cleared
module keypoint_fetch_merge
  import keypoint_fetch_merge_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [ADDR_W-1:0]       kp1_count_i,
  input  logic [ADDR_W-1:0]       kp2_count_i,
  output logic [ADDR_W-1:0]       keypoint_1_addr_o,
  input  logic [KP_W-1:0]         keypoint_1_dout_i,
  output logic [ADDR_W-1:0]       keypoint_2_addr_o,
  input  logic [KP_W-1:0]         keypoint_2_dout_i,
  output logic                    busy_o,
  output logic                    done_o,
  keypoint_fetch_merge_if.master  kp_o
);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr1_q, addr1_d, addr2_q, addr2_d;
  logic [ADDR_W-1:0]   cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [RD_LAT-1:0]   pipe_vld_q, pipe_vld_d, pipe_layer_q, pipe_layer_d, pipe_last_q, pipe_last_d;
  logic [INFL_W-1:0]   infl_q, infl_d;

  logic                issue, issue_layer, issue_last;
  logic                ret_vld, ret_layer;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FCNT_W-1:0]   fifo_count;
  kp_entry_t           fifo_wdata, fifo_rdata;
  logic [CR_W-1:0]     credit_used;
  logic                credit_ok, drain_done;

  assign ret_vld   = pipe_vld_q[RD_LAT-1];
  assign ret_layer = pipe_layer_q[RD_LAT-1];
  assign fifo_pop  = !fifo_empty && kp_o.ready;
  assign fifo_push = ret_vld && (!fifo_full || fifo_pop);
  assign fifo_wdata = kp_unpack(ret_layer, pipe_last_q[RD_LAT-1],
                                ret_layer ? keypoint_2_dout_i : keypoint_1_dout_i);

  // The entry leaving this cycle frees its slot in time for a fresh issue, keeping 1 word/cycle.
  assign credit_used = CR_W'(fifo_count) + CR_W'(infl_q) - CR_W'(fifo_pop);
  assign credit_ok   = (credit_used < CR_W'(FIFO_D));
  assign drain_done  = (infl_q == '0) &&
                       ((fifo_count == '0) || ((fifo_count == FCNT_W'(1)) && fifo_pop));

  always_comb begin
    state_d     = state_q;
    addr1_d     = addr1_q;
    addr2_d     = addr2_q;
    cnt1_d      = cnt1_q;
    cnt2_d      = cnt2_q;
    issue       = 1'b0;
    issue_layer = 1'b0;
    issue_last  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cnt1_d = kp1_count_i;
          cnt2_d = kp2_count_i;
          if (kp1_count_i != '0)      state_d = S_RD1;
          else if (kp2_count_i != '0) state_d = S_RD2;
          else                        state_d = S_FIN;
        end
      end
      S_RD1: begin
        if (credit_ok) begin
          issue   = 1'b1;
          addr1_d = addr1_q + ADDR_W'(1);
          if (addr1_q == cnt1_q - ADDR_W'(1)) begin
            issue_last = (cnt2_q == '0);
            state_d    = (cnt2_q != '0) ? S_RD2 : S_DRAIN;
          end
        end
      end
      S_RD2: begin
        if (credit_ok) begin
          issue       = 1'b1;
          issue_layer = 1'b1;
          addr2_d     = addr2_q + ADDR_W'(1);
          if (addr2_q == cnt2_q - ADDR_W'(1)) begin
            issue_last = 1'b1;
            state_d    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drain_done) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
        addr1_d = '0;
        addr2_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pipe_vld_d      = pipe_vld_q;
    pipe_layer_d    = pipe_layer_q;
    pipe_last_d     = pipe_last_q;
    pipe_vld_d[0]   = issue;
    pipe_layer_d[0] = issue_layer;
    pipe_last_d[0]  = issue_last;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i]   = pipe_vld_q[i-1];
      pipe_layer_d[i] = pipe_layer_q[i-1];
      pipe_last_d[i]  = pipe_last_q[i-1];
    end
    infl_d = infl_q + INFL_W'(issue) - INFL_W'(ret_vld);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr1_q      <= '0;
      addr2_q      <= '0;
      cnt1_q       <= '0;
      cnt2_q       <= '0;
      pipe_vld_q   <= '0;
      pipe_layer_q <= '0;
      pipe_last_q  <= '0;
      infl_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr1_q      <= addr1_d;
      addr2_q      <= addr2_d;
      cnt1_q       <= cnt1_d;
      cnt2_q       <= cnt2_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_layer_q <= pipe_layer_d;
      pipe_last_q  <= pipe_last_d;
      infl_q       <= infl_d;
    end
  end

  keypoint_fetch_merge_skid_fifo #(
    .DEPTH (FIFO_D),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign keypoint_1_addr_o = addr1_q;
  assign keypoint_2_addr_o = addr2_q;
  assign kp_o.valid = !fifo_empty;
  assign kp_o.row   = fifo_rdata.row;
  assign kp_o.col   = fifo_rdata.col;
  assign kp_o.layer = fifo_rdata.layer;
  assign kp_o.last  = fifo_rdata.last;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_FIN);
endmodule

// File: tb/tb_keypoint_fetch_merge.sv
// Directed bench for keypoint_fetch_merge: vector table of runs plus hand-written corner sequences.
module tb_keypoint_fetch_merge;
  import keypoint_fetch_merge_pkg::*;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [ADDR_W-1:0] kp1_count, kp2_count, addr1, addr2;
  logic [KP_W-1:0]   dout1, dout2;
  logic              busy, done;
  logic [KP_W-1:0]   mem1 [2048];
  logic [KP_W-1:0]   mem2 [2048];
  int                total = 0;
  int                bad = 0;

  keypoint_fetch_merge_if kpif();

  keypoint_fetch_merge dut (
    .clk               (clk),
    .rst               (rst),
    .start_i           (start),
    .kp1_count_i       (kp1_count),
    .kp2_count_i       (kp2_count),
    .keypoint_1_addr_o (addr1),
    .keypoint_1_dout_i (dout1),
    .keypoint_2_addr_o (addr2),
    .keypoint_2_dout_i (dout2),
    .busy_o            (busy),
    .done_o            (done),
    .kp_o              (kpif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dout1 <= mem1[addr1];
    dout2 <= mem2[addr2];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int kp1; int kp2; int rmode; int exp_n; int exp_first; int exp_consec;
  } vec_t;

  typedef struct {
    logic layer; logic last; int row; int col;
  } exp_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void fill_mems();
    for (int i = 0; i < 2048; i++) begin
      mem1[i] = KP_W'(i * 1237 + 77);
      mem2[i] = KP_W'(i * 3001 + 500);
    end
  endfunction

  // rmode: 0 ready held 1, 1 ready pattern 1,0,0,1 with an extra start mid-run, 2 random ready
  task automatic run_case(input int kp1, input int kp2, input int rmode,
                          output int n_xfer, output int first_c, output int max_consec,
                          output int done_c, output int last_c, output int addr1_max);
    exp_t q[$];
    exp_t e;
    int   idx = 0;
    int   consec = 0;
    for (int i = 0; i < kp1; i++) begin
      e.layer = 1'b0; e.last = (kp2 == 0) && (i == kp1 - 1);
      e.row = int'(mem1[i][ROW_MSB:ROW_LSB]); e.col = int'(mem1[i][COL_MSB:COL_LSB]);
      q.push_back(e);
    end
    for (int i = 0; i < kp2; i++) begin
      e.layer = 1'b1; e.last = (i == kp2 - 1);
      e.row = int'(mem2[i][ROW_MSB:ROW_LSB]); e.col = int'(mem2[i][COL_MSB:COL_LSB]);
      q.push_back(e);
    end
    n_xfer = 0; first_c = -1; max_consec = 0; done_c = -1; last_c = -1; addr1_max = 0;
    kp1_count = ADDR_W'(kp1);
    kp2_count = ADDR_W'(kp2);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    for (int c = 0; c < 300; c++) begin
      if (rmode == 0)      kpif.ready = 1'b1;
      else if (rmode == 1) kpif.ready = (c % 4 == 0) || (c % 4 == 3);
      else                 kpif.ready = 1'($urandom_range(0, 1));
      start = (rmode == 1) && (c == 3);
      if (start) begin
        kp1_count = ADDR_W'(5);
        kp2_count = ADDR_W'(5);
      end
      if (int'(addr1) > addr1_max) addr1_max = int'(addr1);
      if (kpif.valid) begin
        if (first_c < 0) first_c = c;
        consec++;
        if (consec > max_consec) max_consec = consec;
        if (idx < q.size()) begin
          chk($sformatf("row[%0d]", idx),   int'(kpif.row),   q[idx].row);
          chk($sformatf("col[%0d]", idx),   int'(kpif.col),   q[idx].col);
          chk($sformatf("layer[%0d]", idx), int'(kpif.layer), int'(q[idx].layer));
          if (kpif.ready) chk($sformatf("last[%0d]", idx), int'(kpif.last), int'(q[idx].last));
        end else begin
          chk("extra_valid", 1, 0);
        end
        if (kpif.ready) begin
          idx++;
          n_xfer++;
          last_c = c;
        end
      end else begin
        consec = 0;
      end
      if (done) begin
        done_c = c;
        break;
      end
      step();
    end
    start = 1'b0;
    if (done_c < 0) chk("done_timeout", 0, 1);
    step();
    chk("busy_after_done", int'(busy), 0);
    chk("done_one_cycle", int'(done), 0);
    chk("valid_after_done", int'(kpif.valid), 0);
  endtask

  vec_t vecs[6];
  int   n, fc, mc, dc, lc, am;

  initial begin
    fill_mems();
    rst = 1'b1; start = 1'b0; kpif.ready = 1'b0;
    kp1_count = '0; kp2_count = '0;
    step(); step();
    chk("rst_valid", int'(kpif.valid), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_addr1", int'(addr1), 0);
    chk("rst_addr2", int'(addr2), 0);
    chk("rst_row",   int'(kpif.row), 0);
    chk("rst_col",   int'(kpif.col), 0);
    chk("rst_tag",   int'({kpif.layer, kpif.last}), 0);
    rst = 1'b0;
    step();

    vecs[0] = '{kp1: 3, kp2: 2, rmode: 0, exp_n: 5, exp_first: 2, exp_consec: 5};
    vecs[1] = '{kp1: 0, kp2: 0, rmode: 0, exp_n: 0, exp_first: -1, exp_consec: 0};
    vecs[2] = '{kp1: 0, kp2: 4, rmode: 0, exp_n: 4, exp_first: 2, exp_consec: 4};
    vecs[3] = '{kp1: 6, kp2: 0, rmode: 1, exp_n: 6, exp_first: 2, exp_consec: 0};
    vecs[4] = '{kp1: 1, kp2: 1, rmode: 0, exp_n: 2, exp_first: 2, exp_consec: 2};
    vecs[5] = '{kp1: 4, kp2: 3, rmode: 2, exp_n: 7, exp_first: 2, exp_consec: 0};

    for (int v = 0; v < 6; v++) begin
      run_case(vecs[v].kp1, vecs[v].kp2, vecs[v].rmode, n, fc, mc, dc, lc, am);
      chk($sformatf("v%0d_xfers", v), n, vecs[v].exp_n);
      chk($sformatf("v%0d_first_valid", v), fc, vecs[v].exp_first);
      if (vecs[v].exp_n == 0) begin
        chk($sformatf("v%0d_empty_done_window", v), int'(dc >= 0 && dc <= 2), 1);
      end else begin
        chk($sformatf("v%0d_done_gap", v), dc - lc, 1);
      end
      if (vecs[v].exp_consec > 0) chk($sformatf("v%0d_consec_valid", v), mc, vecs[v].exp_consec);
      if (vecs[v].kp1 == 0) chk($sformatf("v%0d_addr1_max", v), am, 0);
    end

    // field unpack on boundary words
    mem1[0] = 19'h7FC01;
    mem1[1] = 19'h00A7F;
    kpif.ready = 1'b0;
    kp1_count = ADDR_W'(2); kp2_count = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 10 && !kpif.valid; k++) step();
    chk("unpack0_valid", int'(kpif.valid), 1);
    chk("unpack0_row", int'(kpif.row), 511);
    chk("unpack0_col", int'(kpif.col), 1);
    chk("unpack0_last", int'(kpif.last), 0);
    step();
    chk("stall_row_held", int'(kpif.row), 511);
    kpif.ready = 1'b1;
    step();
    chk("unpack1_row", int'(kpif.row), 2);
    chk("unpack1_col", int'(kpif.col), 639);
    chk("unpack1_last", int'(kpif.last), 1);
    step();
    chk("unpack_done", int'(done), 1);
    step();
    chk("unpack_idle", int'(busy), 0);
    fill_mems();

    // reset in the middle of layer-1 reads with two words buffered
    kp1_count = ADDR_W'(2); kp2_count = ADDR_W'(8);
    kpif.ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      kpif.ready = (c < 4);
      step();
    end
    chk("mid_valid", int'(kpif.valid), 1);
    chk("mid_addr1", int'(addr1), 2);
    chk("mid_addr2", int'(addr2), 2);
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_valid", int'(kpif.valid), 0);
    chk("mrst_addr1", int'(addr1), 0);
    chk("mrst_addr2", int'(addr2), 0);
    chk("mrst_busy", int'(busy), 0);
    for (int k = 0; k < 3; k++) begin
      chk("mrst_no_done", int'(done), 0);
      step();
    end
    run_case(2, 0, 0, n, fc, mc, dc, lc, am);
    chk("replay_xfers", n, 2);
    chk("replay_first_valid", fc, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
